// File: rtl/instr_fetch_unit_if.sv
// Instruction-ROM read channel between the fetch unit (master) and the ROM (slave).
//   rom_req  : read request, held until acknowledged
//   rom_addr : word address, stable for the whole request
//   rom_ack  : acknowledge; rom_data is valid in the same cycle
//   rom_data : instruction/immediate word returned by the ROM
interface instr_fetch_unit_if;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 16;

  logic              rom_req;
  logic [ADDR_W-1:0] rom_addr;
  logic              rom_ack;
  logic [DATA_W-1:0] rom_data;

  modport master (output rom_req, rom_addr, input rom_ack, rom_data);
  modport slave  (input rom_req, rom_addr, output rom_ack, rom_data);
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the program counter, fetches one- and two-word
// instructions from the instruction ROM and hands the decoded fields back to
// the control sequencer.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   ins_load            : fetch request pulse (ignored while busy, flagged in ins_drop)
//   pc_load/pc_inc/pc_din : PC jump (priority) / increment
//   rom                 : ROM read channel (master side)
//   opcode/op1_sel/op2_sel : combinational fields of IR
//   imm                 : second word of a two-word instruction
//   ins_valid/imm_valid : one-cycle update pulses
//   busy, ins_drop, fetch_err, pc : status
// Optional feature: define IFU_TIMEOUT_EN to abort a fetch after 15 cycles
// without acknowledge (sticky fetch_err); otherwise the unit waits forever.
module instr_fetch_unit (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ins_load,
  input  logic                    pc_load,
  input  logic                    pc_inc,
  input  logic [7:0]              pc_din,
  instr_fetch_unit_if.master      rom,
  output logic [3:0]              opcode,
  output logic [2:0]              op1_sel,
  output logic [2:0]              op2_sel,
  output logic [15:0]             imm,
  output logic                    ins_valid,
  output logic                    imm_valid,
  output logic                    busy,
  output logic                    ins_drop,
  output logic                    fetch_err,
  output logic [7:0]              pc
);
  localparam int unsigned PC_W   = 8;
  localparam int unsigned WORD_W = 16;

  typedef enum logic [1:0] {IDLE, FETCH1, FETCH2} state_e;

  state_e              state_q, state_d;
  logic                rom_req_q, rom_req_d;
  logic [PC_W-1:0]     rom_addr_q, rom_addr_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [WORD_W-1:0]   ir_q, ir_d;
  logic [WORD_W-1:0]   imm_q, imm_d;
  logic                word2_pend_q, word2_pend_d;
  logic                ins_valid_q, ins_valid_d;
  logic                imm_valid_q, imm_valid_d;
  logic                busy_q, busy_d;
  logic                ins_drop_q, ins_drop_d;
  logic                is_two_word;

`ifdef IFU_TIMEOUT_EN
  localparam int unsigned TMO_W = 4;
  // Value seen in the 15th requesting cycle; no ack there aborts the fetch.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(14);
  logic [TMO_W-1:0]    tmo_cnt_q, tmo_cnt_d;
  logic                fetch_err_q, fetch_err_d;
`endif

  // MVI (1100) and LDA (1101) carry a second immediate word.
  assign is_two_word = (rom.rom_data[15:12] == 4'b1100) || (rom.rom_data[15:12] == 4'b1101);

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    rom_req_d    = rom_req_q;
    rom_addr_d   = rom_addr_q;
    ir_d         = ir_q;
    imm_d        = imm_q;
    word2_pend_d = word2_pend_q;
    ins_valid_d  = 1'b0;
    imm_valid_d  = 1'b0;
    busy_d       = busy_q;
    ins_drop_d   = ins_drop_q;
`ifdef IFU_TIMEOUT_EN
    tmo_cnt_d    = tmo_cnt_q;
    fetch_err_d  = fetch_err_q;
`endif

    // PC may move in any state; a jump beats an increment.
    if (pc_load)     pc_d = pc_din;
    else if (pc_inc) pc_d = pc_q + PC_W'(1);
    else             pc_d = pc_q;

    case (state_q)
      IDLE: begin
        if (ins_load) begin
          state_d    = word2_pend_q ? FETCH2 : FETCH1;
          rom_req_d  = 1'b1;
          rom_addr_d = pc_q;
          busy_d     = 1'b1;
`ifdef IFU_TIMEOUT_EN
          tmo_cnt_d  = '0;
`endif
        end
      end
      FETCH1, FETCH2: begin
        if (ins_load) ins_drop_d = 1'b1;
        if (rom.rom_ack) begin
          if (state_q == FETCH1) begin
            ir_d         = rom.rom_data;
            word2_pend_d = is_two_word;
            ins_valid_d  = 1'b1;
          end else begin
            imm_d        = rom.rom_data;
            word2_pend_d = 1'b0;
            imm_valid_d  = 1'b1;
          end
          state_d   = IDLE;
          rom_req_d = 1'b0;
          busy_d    = 1'b0;
        end else begin
`ifdef IFU_TIMEOUT_EN
          if (tmo_cnt_q == TMO_LAST) begin
            state_d     = IDLE;
            rom_req_d   = 1'b0;
            busy_d      = 1'b0;
            fetch_err_d = 1'b1;
          end else begin
            tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      rom_req_q    <= 1'b0;
      rom_addr_q   <= '0;
      pc_q         <= '0;
      ir_q         <= '0;
      imm_q        <= '0;
      word2_pend_q <= 1'b0;
      ins_valid_q  <= 1'b0;
      imm_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      ins_drop_q   <= 1'b0;
`ifdef IFU_TIMEOUT_EN
      tmo_cnt_q    <= '0;
      fetch_err_q  <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      rom_req_q    <= rom_req_d;
      rom_addr_q   <= rom_addr_d;
      pc_q         <= pc_d;
      ir_q         <= ir_d;
      imm_q        <= imm_d;
      word2_pend_q <= word2_pend_d;
      ins_valid_q  <= ins_valid_d;
      imm_valid_q  <= imm_valid_d;
      busy_q       <= busy_d;
      ins_drop_q   <= ins_drop_d;
`ifdef IFU_TIMEOUT_EN
      tmo_cnt_q    <= tmo_cnt_d;
      fetch_err_q  <= fetch_err_d;
`endif
    end
  end

  assign rom.rom_req  = rom_req_q;
  assign rom.rom_addr = rom_addr_q;
  assign opcode       = ir_q[15:12];
  assign op1_sel      = ir_q[11:9];
  assign op2_sel      = ir_q[8:6];
  assign imm          = imm_q;
  assign ins_valid    = ins_valid_q;
  assign imm_valid    = imm_valid_q;
  assign busy         = busy_q;
  assign ins_drop     = ins_drop_q;
  assign pc           = pc_q;
`ifdef IFU_TIMEOUT_EN
  assign fetch_err    = fetch_err_q;
`else
  assign fetch_err    = 1'b0;
`endif
endmodule
